hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencer for the F/D/E core: generates stall and flush controls around the decode stage register.
- Detects load-use hazards between the instruction in D and a load in E.
- Squashes wrong-path instructions after a taken branch or jump resolved in E.
- Freezes the whole front end while data memory is busy; keeps saturating stall/flush performance counters.

Parameters:
- BRANCH_PENALTY, 2: number of consecutive cycles flush is asserted after a taken branch (allowed range 1..4).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- srcreg1_num  in  5  rs1 of the instruction in D (raw IR field).
- srcreg2_num  in  5  rs2 of the instruction in D.
- use_r1  in  1  instruction in D reads rs1.
- use_r2  in  1  instruction in D reads rs2.
- E_info_load  in  3  load info of the instruction in E; NOTLOAD means not a load.
- E_dstreg_num  in  5  destination register of the instruction in E.
- branch_taken  in  1  E resolved a taken branch, JAL or JALR this cycle.
- mem_busy  in  1  data memory cannot complete this cycle.
- stall_fd  out  1  hold the PC and IR (F/D registers).
- stall_e  out  1  hold the E/M registers.
- flush  out  1  decoder flush: inject a bubble into E.
- state_o  out  2  current FSM state, for debug.
- perf_stall  out  CNT_W  count of cycles with stall_fd=1.
- perf_flush  out  CNT_W  count of cycles with flush=1.

Behaviour:
- Reset: synchronous, active-high, sampled on posedge clk. Next state is RUN; all outputs are 0; both counters clear to 0. rst has priority over every other input.
- FSM states: RUN=0, REDIRECT=1, MEMWAIT=2. state_o is registered.
- Hazard term: ldhaz = (E_info_load != NOTLOAD) && (E_dstreg_num != 0) && ((use_r1 && srcreg1_num == E_dstreg_num) || (use_r2 && srcreg2_num == E_dstreg_num)).
- Outputs are combinational from state and inputs; state and counters are registered.
- Priority every cycle, highest first: mem_busy, then branch_taken / REDIRECT, then ldhaz.
- RUN state:
  - mem_busy=1: stall_fd=1, stall_e=1, flush=0; go to MEMWAIT.
  - else branch_taken=1: flush=1, stall_fd=0. Load rem = BRANCH_PENALTY-1. If rem>0 go to REDIRECT, else stay in RUN.
  - else ldhaz=1: stall_fd=1, flush=1, stall_e=0, so one bubble enters E. Stay in RUN; the hazard clears naturally the next cycle.
  - else: all outputs 0.
- REDIRECT state:
  - flush=1 and stall_fd=0; decrement rem; when rem reaches 0, return to RUN.
  - ldhaz is ignored (wrong-path instruction).
  - mem_busy=1: stall_fd=1, stall_e=1, flush=0, rem frozen, stay in REDIRECT.
  - A new branch_taken is impossible here (E holds a bubble); if one arrives anyway, reload rem = BRANCH_PENALTY-1.
- MEMWAIT state:
  - stall_fd=1, stall_e=1, flush=0 while mem_busy=1.
  - When mem_busy falls, evaluate that same cycle with RUN rules and take RUN's next-state.
- A branch coinciding with ldhaz: branch wins and no stall is taken.
- Counters:
  - perf_stall increments on any cycle with stall_fd=1.
  - perf_flush increments on any cycle with flush=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-REDIRECT or mid-MEMWAIT: next cycle is RUN with all outputs 0; the pending flush is discarded.

Decomposition:
- Shared include (define header): NOTLOAD, TRUE, FALSE, and new state codes HC_RUN, HC_REDIRECT, HC_MEMWAIT.
- One natural sub-module: sat_counter (parameter W; ports clk, rst, inc, q), instantiated twice.

Test Plan:
- Reset: assert rst for 2 cycles from random state -> state_o=0, all outputs 0, perf_stall=perf_flush=0.
- Load-use: E_info_load=LW, E_dstreg_num=5, D srcreg1_num=5, use_r1=1 -> stall_fd=1 and flush=1 for exactly 1 cycle. Same case with E_dstreg_num=0 or use_r1=0 -> no stall.
- Branch: branch_taken pulse with BRANCH_PENALTY=2 -> flush=1 for 2 consecutive cycles, stall_fd=0, perf_flush=2.
- Branch plus memory: branch_taken, then mem_busy=1 for 3 cycles in REDIRECT -> flush low and stalls high for 3 cycles, then flush=1 for 1 more cycle, then RUN.
- Priority: mem_busy=1, branch_taken=1 and ldhaz together -> stall_fd=stall_e=1, flush=0, state MEMWAIT. After mem_busy drops with branch_taken still 1 -> flush=1.
- Saturation: preload perf_stall to all-ones (CNT_W=4 build), hold mem_busy -> stays at 15. Then rst in MEMWAIT -> counters 0, state RUN.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared definitions for the F/D/E hazard sequencer: load-info encodings,
// boolean constants, FSM state codes and the load-use hazard helper.
package hazard_ctrl_pkg;

    // Load-info encodings carried with the instruction in E.
    // NOTLOAD marks an instruction that does not read data memory.
    localparam logic [2:0] NOTLOAD = 3'd0;
    localparam logic [2:0] LB      = 3'd1;
    localparam logic [2:0] LH      = 3'd2;
    localparam logic [2:0] LW      = 3'd3;
    localparam logic [2:0] LBU     = 3'd4;
    localparam logic [2:0] LHU     = 3'd5;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        HC_RUN      = 2'd0,
        HC_REDIRECT = 2'd1,
        HC_MEMWAIT  = 2'd2
    } hc_state_t;

    // Register x0 is hard-wired to zero, so a load targeting it never
    // creates a real dependency.
    function automatic logic load_use_hazard(
        input logic [2:0] e_info_load,
        input logic [4:0] e_dstreg_num,
        input logic       use_r1,
        input logic [4:0] srcreg1_num,
        input logic       use_r2,
        input logic [4:0] srcreg2_num
    );
        return (e_info_load != NOTLOAD) && (e_dstreg_num != 5'd0) &&
               ((use_r1 && (srcreg1_num == e_dstreg_num)) ||
                (use_r2 && (srcreg2_num == e_dstreg_num)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter
// Saturating up-counter used for the performance counters.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, clears q
//   inc  - count enable for this cycle
//   q    - current count; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline sequencer for the F/D/E core. Generates stall and flush controls
// around the decode stage register: load-use bubbles, wrong-path squashing
// after a taken branch/jump resolved in E, and a full front-end freeze while
// data memory is busy. Keeps saturating stall/flush performance counters.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   srcreg1_num, srcreg2_num  - rs1/rs2 of the instruction in D
//   use_r1, use_r2            - instruction in D actually reads rs1/rs2
//   E_info_load, E_dstreg_num - load info and rd of the instruction in E
//   branch_taken              - E resolved a taken branch/JAL/JALR
//   mem_busy                  - data memory cannot complete this cycle
//   stall_fd, stall_e, flush  - pipeline controls (combinational)
//   state_o                   - registered FSM state for debug
//   perf_stall, perf_flush    - saturating cycle counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       srcreg1_num,
    input  logic [4:0]       srcreg2_num,
    input  logic             use_r1,
    input  logic             use_r2,
    input  logic [2:0]       E_info_load,
    input  logic [4:0]       E_dstreg_num,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             stall_fd,
    output logic             stall_e,
    output logic             flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush
);

    // rem counts the flush cycles still owed after the current one.
    localparam logic [1:0] REM_INIT = 2'(BRANCH_PENALTY - 1);

    hc_state_t  state, next_state;
    logic [1:0] rem, rem_next;
    logic       ldhaz;
    logic       stall_fd_c, stall_e_c, flush_c;

    assign ldhaz = load_use_hazard(E_info_load, E_dstreg_num, use_r1,
                                   srcreg1_num, use_r2, srcreg2_num);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HC_RUN;
            rem   <= 2'd0;
        end else begin
            state <= next_state;
            rem   <= rem_next;
        end
    end

    // MEMWAIT behaves exactly like RUN: while mem_busy is high RUN's top
    // priority rule holds the freeze, and once it drops RUN's remaining
    // rules are evaluated in that same cycle.
    always_comb begin
        next_state = state;
        rem_next   = rem;
        stall_fd_c = FALSE;
        stall_e_c  = FALSE;
        flush_c    = FALSE;

        case (state)
            HC_REDIRECT: begin
                if (mem_busy) begin
                    stall_fd_c = TRUE;
                    stall_e_c  = TRUE;
                end else if (branch_taken) begin
                    flush_c    = TRUE;
                    rem_next   = REM_INIT;
                    next_state = (REM_INIT != 2'd0) ? HC_REDIRECT : HC_RUN;
                end else begin
                    // ldhaz deliberately ignored: D holds a wrong-path instruction.
                    flush_c    = TRUE;
                    rem_next   = rem - 2'd1;
                    next_state = (rem <= 2'd1) ? HC_RUN : HC_REDIRECT;
                end
            end
            default: begin
                if (mem_busy) begin
                    stall_fd_c = TRUE;
                    stall_e_c  = TRUE;
                    next_state = HC_MEMWAIT;
                end else if (branch_taken) begin
                    flush_c    = TRUE;
                    rem_next   = REM_INIT;
                    next_state = (REM_INIT != 2'd0) ? HC_REDIRECT : HC_RUN;
                end else if (ldhaz) begin
                    // Hold F/D and push one bubble into E.
                    stall_fd_c = TRUE;
                    flush_c    = TRUE;
                    next_state = HC_RUN;
                end else begin
                    next_state = HC_RUN;
                end
            end
        endcase

        if (rst) begin
            stall_fd_c = FALSE;
            stall_e_c  = FALSE;
            flush_c    = FALSE;
        end
    end

    assign stall_fd = stall_fd_c;
    assign stall_e  = stall_e_c;
    assign flush    = flush_c;
    assign state_o  = state;

    sat_counter #(.W(CNT_W)) u_perf_stall (
        .clk (clk),
        .rst (rst),
        .inc (stall_fd_c),
        .q   (perf_stall)
    );

    sat_counter #(.W(CNT_W)) u_perf_flush (
        .clk (clk),
        .rst (rst),
        .inc (flush_c),
        .q   (perf_flush)
    );

endmodule
